// File: rtl/sprite_fetch.sv
// sprite_fetch: pixel-side reader for one animated sprite.
// Once per frame, on the vsync falling edge, it copies the controller's sprite
// position, frame index and enable into shadow registers. For every pixel it
// turns DrawX/DrawY into a sprite ROM address. It returns the palette index,
// aligned to the ROM latency, with a valid flag.
// It also divides vsync down to the Anim_tick pulse that advances the
// animation controller.
// Optional build macro: SPRITE_HFLIP_EN adds the Flip input. Flip mirrors the
// sprite horizontally and is latched with the other shadow registers.
module sprite_fetch #(
    parameter int SPR_W       = 48,
    parameter int SPR_H       = 48,
    parameter int NUM_FRAMES  = 32,
    parameter int ADDR_W      = 17,
    parameter int ROM_LATENCY = 1,
    parameter int ANIM_DIV    = 6,
    parameter int TRANSPARENT = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        Sprite_X,
    input  logic [9:0]        Sprite_Y,
    input  logic [4:0]        Frame,
    input  logic              Sprite_en,
`ifdef SPRITE_HFLIP_EN
    input  logic              Flip,
`endif
    output logic [ADDR_W-1:0] Rom_addr,
    input  logic [3:0]        Rom_data,
    output logic [3:0]        Pixel_idx,
    output logic              Pixel_valid,
    output logic              Anim_tick
);

    localparam int               DIV_W         = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(ANIM_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE       = DIV_W'(1);
    localparam logic [10:0]      SPR_W_11      = 11'(SPR_W);
    localparam logic [10:0]      SPR_H_11      = 11'(SPR_H);
    localparam logic [31:0]      FRAME_PIX_32  = 32'(SPR_W * SPR_H);
    localparam logic [31:0]      SPR_W_32      = 32'(SPR_W);
    localparam logic [31:0]      NUM_FRAMES_32 = 32'(NUM_FRAMES);
    localparam logic [3:0]       TRANSP_4      = 4'(TRANSPARENT);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_WAIT_HI = 2'd2
    } cap_state_t;

    // Linear ROM address: frame base + row offset + column, truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] calc_addr(
        input logic [4:0]  frame_idx,
        input logic [10:0] row,
        input logic [10:0] col
    );
        return ADDR_W'((32'(frame_idx) * FRAME_PIX_32) + (32'(row) * SPR_W_32) + 32'(col));
    endfunction

    // vsync sampling and edge detection
    logic              vsync_q_r;
    logic              vsync_qq_r;
    logic              vsync_fall_s;

    // capture FSM, shadow registers, animation divider
    cap_state_t        state_r;
    logic [9:0]        x_r;
    logic [9:0]        y_r;
    logic [4:0]        frame_r;
    logic              en_r;
`ifdef SPRITE_HFLIP_EN
    logic              flip_r;
`endif
    logic [DIV_W-1:0]  div_cnt_r;

    // stage 0 combinational terms
    logic [10:0]       draw_x_s;
    logic [10:0]       draw_y_s;
    logic [10:0]       org_x_s;
    logic [10:0]       org_y_s;
    logic [10:0]       dx_s;
    logic [10:0]       dy_s;
    logic [10:0]       dx_eff_s;
    logic              frame_ok_s;
    logic              inside_s;
    logic [ADDR_W-1:0] addr_s;

    // pipeline
    logic                   inside_r;
    logic [ROM_LATENCY-1:0] inside_pipe_r;
    logic                   pix_valid_s;

    // Two sampling flops. The registered edge ignores glitches shorter than one clock.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vsync_q_r  <= 1'b1;
            vsync_qq_r <= 1'b1;
        end else begin
            vsync_q_r  <= vsync;
            vsync_qq_r <= vsync_q_r;
        end
    end

    assign vsync_fall_s = vsync_qq_r & ~vsync_q_r;

    // Capture FSM. Latches the shadow state once per frame and advances the divider.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= ST_ARMED;
            x_r       <= 10'd0;
            y_r       <= 10'd0;
            frame_r   <= 5'd0;
            en_r      <= 1'b0;
`ifdef SPRITE_HFLIP_EN
            flip_r    <= 1'b0;
`endif
            div_cnt_r <= {DIV_W{1'b0}};
            Anim_tick <= 1'b0;
        end else begin
            Anim_tick <= 1'b0;
            case (state_r)
                ST_ARMED: begin
                    if (vsync_fall_s) begin
                        state_r <= ST_LATCH;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_LATCH: begin
                    x_r     <= Sprite_X;
                    y_r     <= Sprite_Y;
                    frame_r <= Frame;
                    en_r    <= Sprite_en;
`ifdef SPRITE_HFLIP_EN
                    flip_r  <= Flip;
`endif
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= {DIV_W{1'b0}};
                        Anim_tick <= 1'b1;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                    state_r <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (vsync_q_r) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_WAIT_HI;
                    end
                end
                default: begin
                    state_r <= ST_ARMED;
                end
            endcase
        end
    end

    // Coverage test and address math at 11 bits, so a sprite near the right edge clips instead of wrapping.
    always_comb begin
        draw_x_s   = {1'b0, DrawX};
        draw_y_s   = {1'b0, DrawY};
        org_x_s    = {1'b0, x_r};
        org_y_s    = {1'b0, y_r};
        frame_ok_s = ({27'd0, frame_r} < NUM_FRAMES_32);
        inside_s   = en_r && frame_ok_s
                     && (draw_x_s >= org_x_s) && (draw_x_s < (org_x_s + SPR_W_11))
                     && (draw_y_s >= org_y_s) && (draw_y_s < (org_y_s + SPR_H_11));
        dx_s       = draw_x_s - org_x_s;
        dy_s       = draw_y_s - org_y_s;
`ifdef SPRITE_HFLIP_EN
        dx_eff_s   = flip_r ? (SPR_W_11 - 11'd1 - dx_s) : dx_s;
`else
        dx_eff_s   = dx_s;
`endif
        addr_s     = inside_s ? calc_addr(frame_r, dy_s, dx_eff_s) : {ADDR_W{1'b0}};
    end

    // Stage 0: register the ROM address and whether the pixel is inside the sprite.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Rom_addr <= {ADDR_W{1'b0}};
            inside_r <= 1'b0;
        end else begin
            Rom_addr <= addr_s;
            inside_r <= inside_s;
        end
    end

    // Delay the inside flag by the ROM read latency so it lines up with Rom_data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            inside_pipe_r <= {ROM_LATENCY{1'b0}};
        end else begin
            inside_pipe_r[0] <= inside_r;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                inside_pipe_r[i] <= inside_pipe_r[i-1];
            end
        end
    end

    assign pix_valid_s = inside_pipe_r[ROM_LATENCY-1] && (Rom_data != TRANSP_4);

    // Output stage: opaque covered pixels pass their index, everything else reads as 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Pixel_valid <= 1'b0;
            Pixel_idx   <= 4'd0;
        end else begin
            Pixel_valid <= pix_valid_s;
            Pixel_idx   <= pix_valid_s ? Rom_data : 4'd0;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed and randomized pixel probes
// checked against a behavioural model of the sprite box, ROM stub and divider.
module tb_sprite_fetch;

    localparam int SW  = 48;
    localparam int SH  = 48;
    // Below the 5-bit Frame range so that out-of-range frame indices can be driven.
    localparam int NF  = 24;
    localparam int AW  = 17;
    localparam int DIV = 6;

    logic          Clk       = 1'b0;
    logic          Reset_n   = 1'b0;
    logic          vsync     = 1'b1;
    logic [9:0]    DrawX     = 10'd0;
    logic [9:0]    DrawY     = 10'd0;
    logic [9:0]    Sprite_X  = 10'd0;
    logic [9:0]    Sprite_Y  = 10'd0;
    logic [4:0]    Frame     = 5'd0;
    logic          Sprite_en = 1'b0;
`ifdef SPRITE_HFLIP_EN
    logic          Flip      = 1'b0;
    int            req_flip  = 0;
`endif
    logic [AW-1:0] Rom_addr;
    logic [3:0]    Rom_data  = 4'd0;
    logic [3:0]    Pixel_idx;
    logic          Pixel_valid;
    logic          Anim_tick;

    int tests = 0;
    int fails = 0;

    // model of what the DUT should have latched
    int m_x = 0, m_y = 0, m_frame = 0, m_en = 0, m_flip = 0;

    int   tick_pulses = 0;
    int   tick_cycles = 0;
    logic tick_prev   = 1'b0;

    always #5 Clk = ~Clk;

    sprite_fetch #(
        .SPR_W(SW), .SPR_H(SH), .NUM_FRAMES(NF), .ADDR_W(AW),
        .ROM_LATENCY(1), .ANIM_DIV(DIV), .TRANSPARENT(0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync),
        .DrawX(DrawX), .DrawY(DrawY),
        .Sprite_X(Sprite_X), .Sprite_Y(Sprite_Y),
        .Frame(Frame), .Sprite_en(Sprite_en),
`ifdef SPRITE_HFLIP_EN
        .Flip(Flip),
`endif
        .Rom_addr(Rom_addr), .Rom_data(Rom_data),
        .Pixel_idx(Pixel_idx), .Pixel_valid(Pixel_valid), .Anim_tick(Anim_tick)
    );

    // ROM stub: one cycle of read latency, contents = low nibble of the address
    always @(posedge Clk) Rom_data <= Rom_addr[3:0];

    // Anim_tick monitor: counts high cycles and rising edges
    always @(negedge Clk) begin
        tick_prev <= Anim_tick;
        if (Anim_tick) tick_cycles <= tick_cycles + 1;
        if (Anim_tick && !tick_prev) tick_pulses <= tick_pulses + 1;
    end

    // Model: address of pixel (px,py) in the latched sprite, or -1 if not drawn
    function automatic int model_addr(input int px, input int py);
        int dx;
        if (m_en == 0 || m_frame >= NF) return -1;
        if (px < m_x || px >= m_x + SW || py < m_y || py >= m_y + SH) return -1;
        dx = (m_flip != 0) ? (SW - 1 - (px - m_x)) : (px - m_x);
        return (m_frame * SW * SH + (py - m_y) * SW + dx) % (1 << AW);
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int a);
        if (a < 0) return {AW{1'b0}};
        return AW'(a);
    endfunction

    // {valid, idx} expected from the ROM stub for model address a
    function automatic logic [4:0] exp_pix(input int a);
        if (a < 0 || (a % 16) == 0) return 5'd0;
        return {1'b1, 4'(a % 16)};
    endfunction

    // One vsync frame: present new controller values, pulse vsync, then scramble the inputs while vsync is low
    task automatic latch_frame(input int x, input int y, input int f, input int en);
        @(negedge Clk);
        Sprite_X  = 10'(x);
        Sprite_Y  = 10'(y);
        Frame     = 5'(f);
        Sprite_en = (en != 0);
`ifdef SPRITE_HFLIP_EN
        Flip   = (req_flip != 0);
        m_flip = req_flip;
`endif
        vsync = 1'b0;
        m_x = x; m_y = y; m_frame = f; m_en = en;
        repeat (5) @(negedge Clk);
        Sprite_X  = 10'($urandom);
        Sprite_Y  = 10'($urandom);
        Frame     = 5'($urandom);
        Sprite_en = 1'($urandom);
        repeat (3) @(negedge Clk);
        vsync = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        tests++; if (Rom_addr !== {AW{1'b0}}) begin fails++; $display("FAIL reset_rom_addr: got %0d want 0", Rom_addr); end
        tests++; if (Pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_pixel_valid: got %b want 0", Pixel_valid); end
        tests++; if (Pixel_idx !== 4'd0) begin fails++; $display("FAIL reset_pixel_idx: got %0d want 0", Pixel_idx); end
        tests++; if (Anim_tick !== 1'b0) begin fails++; $display("FAIL reset_anim_tick: got %b want 0", Anim_tick); end
        Reset_n = 1'b1;
        DrawX = 10'd1;
        DrawY = 10'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            tests++; if (Rom_addr !== {AW{1'b0}} || Pixel_valid !== 1'b0) begin
                fails++; $display("FAIL pre_latch_dark: addr %0d valid %b want 0/0", Rom_addr, Pixel_valid);
            end
        end
    endtask

    task automatic test_basic;
        latch_frame(100, 200, 2, 1);
        @(negedge Clk);
        DrawX = 10'd100; DrawY = 10'd200;
        @(negedge Clk);
        tests++; if (Rom_addr !== 17'd4608) begin fails++; $display("FAIL basic_addr: got %0d want 4608", Rom_addr); end
        DrawX = 10'd101;
        @(negedge Clk);
        tests++; if (Rom_addr !== exp_addr(model_addr(101, 200))) begin fails++; $display("FAIL basic_addr2: got %0d want %0d", Rom_addr, model_addr(101, 200)); end
        @(negedge Clk);
        // ROM returns 0 at 4608: transparent, so the pixel is not valid
        tests++; if ({Pixel_valid, Pixel_idx} !== 5'd0) begin fails++; $display("FAIL basic_transparent: got %b/%0d want 0/0", Pixel_valid, Pixel_idx); end
        @(negedge Clk);
        tests++; if ({Pixel_valid, Pixel_idx} !== 5'b1_0001) begin fails++; $display("FAIL basic_pixel: got %b/%0d want 1/1", Pixel_valid, Pixel_idx); end
    endtask

    task automatic test_bounds;
        int sx[10] = '{147, 148,  99, 100, 100, 147, 1023,  5, 1023, 999};
        int sy[10] = '{200, 200, 200, 247, 248, 247,    0,  0,   47,  10};
        int a;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) latch_frame(100, 200, 3, 1);
            if (i == 6) latch_frame(1000, 0, 1, 1);
            @(negedge Clk);
            DrawX = 10'(sx[i]); DrawY = 10'(sy[i]);
            a = model_addr(sx[i], sy[i]);
            @(negedge Clk);
            tests++; if (Rom_addr !== exp_addr(a)) begin fails++; $display("FAIL bounds_addr(%0d,%0d): got %0d want %0d", sx[i], sy[i], Rom_addr, exp_addr(a)); end
            repeat (2) @(negedge Clk);
            tests++; if ({Pixel_valid, Pixel_idx} !== exp_pix(a)) begin fails++; $display("FAIL bounds_pix(%0d,%0d): got %b/%0d want %b", sx[i], sy[i], Pixel_valid, Pixel_idx, exp_pix(a)); end
        end
    endtask

    task automatic test_midframe;
        int a;
        latch_frame(100, 200, 2, 1);
        @(negedge Clk);
        Sprite_X = 10'd300; Sprite_Y = 10'd10; Frame = 5'd7; Sprite_en = 1'b1;
        // sub-clock glitch between edges
        #1 vsync = 1'b0;
        #2 vsync = 1'b1;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            DrawX = (i == 0) ? 10'd101 : 10'd301;
            DrawY = (i == 0) ? 10'd200 : 10'd10;
            a = model_addr(int'(DrawX), int'(DrawY));
            @(negedge Clk);
            tests++; if (Rom_addr !== exp_addr(a)) begin fails++; $display("FAIL midframe_addr%0d: got %0d want %0d", i, Rom_addr, exp_addr(a)); end
        end
        latch_frame(300, 10, 7, 1);
        @(negedge Clk);
        DrawX = 10'd301; DrawY = 10'd10;
        @(negedge Clk);
        tests++; if (Rom_addr !== exp_addr(7 * 2304 + 1)) begin fails++; $display("FAIL midframe_newx: got %0d want %0d", Rom_addr, 7 * 2304 + 1); end
    endtask

    task automatic test_frame_range;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) latch_frame(300, 300, 28, 1);
            else latch_frame(300, 300, 5, 0);
            for (int i = 0; i < 6; i++) begin
                @(negedge Clk);
                DrawX = 10'(301 + i * 7); DrawY = 10'(303 + i * 5);
                repeat (3) @(negedge Clk);
                tests++; if (Rom_addr !== {AW{1'b0}} || Pixel_valid !== 1'b0 || Pixel_idx !== 4'd0) begin
                    fails++; $display("FAIL frame_range%0d_%0d: addr %0d valid %b idx %0d want 0", r, i, Rom_addr, Pixel_valid, Pixel_idx);
                end
            end
        end
    endtask

    task automatic test_random;
        int px, py, a;
        for (int r = 0; r < 6; r++) begin
            latch_frame($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 31),
                        ($urandom_range(0, 7) != 0) ? 1 : 0);
            for (int i = 0; i < 25; i++) begin
                px = (m_x + $urandom_range(0, 59) - 6) & 1023;
                py = (m_y + $urandom_range(0, 59) - 6) & 1023;
                a  = model_addr(px, py);
                @(negedge Clk);
                DrawX = 10'(px); DrawY = 10'(py);
                @(negedge Clk);
                tests++; if (Rom_addr !== exp_addr(a)) begin fails++; $display("FAIL rand_addr(%0d,%0d): got %0d want %0d", px, py, Rom_addr, exp_addr(a)); end
                repeat (2) @(negedge Clk);
                tests++; if ({Pixel_valid, Pixel_idx} !== exp_pix(a)) begin fails++; $display("FAIL rand_pix(%0d,%0d): got %b/%0d want %b", px, py, Pixel_valid, Pixel_idx, exp_pix(a)); end
            end
        end
    endtask

    task automatic test_hflip;
`ifdef SPRITE_HFLIP_EN
        req_flip = 1;
        latch_frame(100, 200, 2, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            DrawX = (i == 0) ? 10'd100 : 10'd147; DrawY = 10'd200;
            @(negedge Clk);
            tests++; if (Rom_addr !== exp_addr((i == 0) ? 4655 : 4608)) begin fails++; $display("FAIL hflip_addr%0d: got %0d", i, Rom_addr); end
        end
        req_flip = 0;
`endif
    endtask

    task automatic test_reset_midline;
        latch_frame(100, 200, 2, 1);
        @(negedge Clk);
        DrawX = 10'd105; DrawY = 10'd201;
        repeat (3) @(negedge Clk);
        tests++; if ({Pixel_valid, Pixel_idx} !== exp_pix(model_addr(105, 201))) begin fails++; $display("FAIL midline_pre: got %b/%0d", Pixel_valid, Pixel_idx); end
        #1 Reset_n = 1'b0;
        m_en = 0;
        #1;
        tests++; if (Rom_addr !== {AW{1'b0}} || Pixel_valid !== 1'b0 || Pixel_idx !== 4'd0 || Anim_tick !== 1'b0) begin
            fails++; $display("FAIL midline_reset: addr %0d valid %b idx %0d tick %b want 0", Rom_addr, Pixel_valid, Pixel_idx, Anim_tick);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            tests++; if (Rom_addr !== {AW{1'b0}} || Pixel_valid !== 1'b0) begin fails++; $display("FAIL midline_dark: addr %0d valid %b want 0/0", Rom_addr, Pixel_valid); end
        end
    endtask

    task automatic test_anim_tick;
        int base_p, base_c;
        #1;
        base_p = tick_pulses;
        base_c = tick_cycles;
        for (int k = 1; k <= 12; k++) begin
            latch_frame(50, 60, 1, 1);
            #1;
            tests++; if (tick_pulses - base_p !== k / DIV) begin fails++; $display("FAIL anim_pulses_after_%0d: got %0d want %0d", k, tick_pulses - base_p, k / DIV); end
        end
        tests++; if (tick_cycles - base_c !== 2) begin fails++; $display("FAIL anim_width: got %0d high cycles want 2", tick_cycles - base_c); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_midframe();
        test_frame_range();
        test_random();
        test_hflip();
        test_reset_midline();
        test_anim_tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
